tt_sweep_ctrl: RTL and testbench

Sequencer that drives an exhaustive truth-table sweep through a small combinational unit, such as the 2-input `f` function block. It applies every input vector in ascending binary order and holds each one for a programmable settle time. It samples the unit's output into a captured truth table, then compares that table against an expected table and reports pass/fail. The block sits between a combinational unit under test and the lab self-check logic, replacing hand-written stimulus sequences.

---
 rtl/tt_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl
// Drives an exhaustive truth-table sweep through a small combinational unit.
// Every input vector is applied in ascending order and held for DWELL cycles.
// The unit output is sampled on the last cycle of each hold into a captured
// table, which is then compared against an expected table latched at start.
//
// Parameters
//   N_IN   number of unit inputs; table width TT_W = 2**N_IN
//   DWELL  cycles each vector is held (1..255)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      sweep request, only honoured while idle
//   expect_tt  expected truth table, latched when start is accepted
//   f_in       output of the unit under test
//   vec_out    vector applied to the unit (0 when not sweeping)
//   busy       high while sweeping and during the compare cycle
//   done       one-cycle pulse when results are valid
//   pass       captured table equals latched expected table
//   tt_out     captured truth table
//   mismatch   per-vector failure flags (tt_out ^ latched expected)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; results of the last sweep are held
// S_DWELL | vector applied, dwell counter running, sample at count 0
// S_CHECK | compare captured table against the latched expectation
// S_DONE  | done pulse, back to idle on the next edge

module tt_sweep_ctrl #(
    parameter int  N_IN  = 2,
    parameter int  DWELL = 20,
    localparam int TT_W  = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TT_W-1:0] expect_tt,
    input  logic            f_in,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [TT_W-1:0] tt_out,
    output logic [TT_W-1:0] mismatch
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [7:0]      DCNT_LOAD = 8'(DWELL - 1);
    localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
    localparam logic [N_IN-1:0] VEC_LAST  = '1;

    state_t          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [7:0]      dcnt_q, dcnt_d;
    logic [TT_W-1:0] exp_q, exp_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic [TT_W-1:0] mis_q, mis_d;
    logic            pass_q, pass_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            dcnt_q  <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            mis_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            dcnt_q  <= dcnt_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            mis_q   <= mis_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        dcnt_d  = dcnt_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        mis_d   = mis_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_DWELL;
                    vec_d   = '0;
                    dcnt_d  = DCNT_LOAD;
                    exp_d   = expect_tt;
                    tt_d    = '0;
                    mis_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            S_DWELL: begin
                if (dcnt_q != 8'd0) begin
                    dcnt_d = dcnt_q - 8'd1;
                end else begin
                    // Last cycle of the hold: the unit has settled.
                    tt_d[vec_q] = f_in;
                    if (vec_q == VEC_LAST) begin
                        state_d = S_CHECK;
                    end else begin
                        vec_d  = vec_q + VEC_ONE;
                        dcnt_d = DCNT_LOAD;
                    end
                end
            end
            S_CHECK: begin
                mis_d   = tt_q ^ exp_q;
                pass_d  = (tt_q == exp_q);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Decoded from the state register so an async reset clears them at once.
    assign vec_out  = (state_q == S_DWELL) ? vec_q : '0;
    assign busy     = (state_q == S_DWELL) || (state_q == S_CHECK);
    assign done     = (state_q == S_DONE);
    assign pass     = pass_q;
    assign tt_out   = tt_q;
    assign mismatch = mis_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Testbench for tt_sweep_ctrl. Several instances with different N_IN/DWELL
// share clk/rst/start; each has its own expected table and emulated unit.
// A timeline model (cycles since the accepting edge) predicts every output
// each cycle; directed sections add hand-computed literal expectations.

module tb_tt_sweep_ctrl;

    localparam int NI = 5;
    localparam int NA [NI] = '{2, 2, 2, 2, 3};
    localparam int DA [NI] = '{2, 20, 4, 1, 3};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] exp_drv [NI];
    logic       f_in    [NI];
    logic [2:0] vec_o   [NI];
    logic       busy_o  [NI];
    logic       done_o  [NI];
    logic       pass_o  [NI];
    logic [7:0] tt_o    [NI];
    logic [7:0] mis_o   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int N = NA[g];
        localparam int T = 1 << N;
        logic [N-1:0] v;
        logic [T-1:0] t, m;
        tt_sweep_ctrl #(.N_IN(N), .DWELL(DA[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .expect_tt (exp_drv[g][T-1:0]),
            .f_in      (f_in[g]),
            .vec_out   (v),
            .busy      (busy_o[g]),
            .done      (done_o[g]),
            .pass      (pass_o[g]),
            .tt_out    (t),
            .mismatch  (m)
        );
        assign vec_o[g] = 3'(v);
        assign tt_o[g]  = 8'(t);
        assign mis_o[g] = 8'(m);
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         fn_sel  = 0;
    logic [7:0] rnd_tbl = 8'h5a;

    // Model state: active sweep, cycle index since accepting edge, tables.
    bit         mact [NI];
    int         mk   [NI];
    logic [7:0] mtt  [NI];
    logic [7:0] mexp [NI];
    logic [7:0] mmis [NI];
    bit         mpass[NI];

    int         dat  [NI];
    logic [7:0] vseq [128];
    logic [7:0] seq_ref [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    function automatic bit fval(input int fn, input int n, input int v);
        case (fn)
            0:       return v == (1 << n) - 1;
            1:       return ($countones(v) % 2) == 1;
            2:       return v != 0;
            default: return rnd_tbl[v];
        endcase
    endfunction

    function automatic logic [7:0] truth(input int fn, input int n);
        logic [7:0] r = '0;
        for (int v = 0; v < (1 << n); v++) r[v] = fval(fn, n, v);
        return r;
    endfunction

    task automatic chk(input string nm, input int i, input logic [7:0] act,
                       input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h",
                         nm, i, cyc, act, want);
        end
    endtask

    task automatic model_step(input int i);
        int l = (1 << NA[i]) * DA[i];
        if (rst) begin
            mact[i] = 0; mk[i] = 0; mtt[i] = '0; mmis[i] = '0; mpass[i] = 0;
        end else if (!mact[i]) begin
            if (start) begin
                mact[i] = 1; mk[i] = 1;
                mexp[i] = exp_drv[i] & 8'((1 << (1 << NA[i])) - 1);
                mtt[i] = '0; mmis[i] = '0; mpass[i] = 0;
            end
        end else begin
            if (mk[i] <= l && mk[i] % DA[i] == 0) mtt[i][mk[i] / DA[i] - 1] = f_in[i];
            if (mk[i] == l + 1) begin
                mmis[i]  = mtt[i] ^ mexp[i];
                mpass[i] = (mtt[i] == mexp[i]);
            end
            if (mk[i] == l + 2) mact[i] = 0;
            else mk[i]++;
        end
    endtask

    // Advance one cycle: update model with what the last edge saw, compare,
    // then present the unit output for the next edge (garbage unless sampled).
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            int  l = (1 << NA[i]) * DA[i];
            int  ev;
            model_step(i);
            ev = (mact[i] && mk[i] <= l) ? (mk[i] - 1) / DA[i] : 0;
            chk("vec_out",  i, 8'(vec_o[i]),  8'(ev));
            chk("busy",     i, 8'(busy_o[i]), 8'(mact[i] && mk[i] <= l + 1));
            chk("done",     i, 8'(done_o[i]), 8'(mact[i] && mk[i] == l + 2));
            chk("tt_out",   i, tt_o[i],  mtt[i]);
            chk("mismatch", i, mis_o[i], mmis[i]);
            chk("pass",     i, 8'(pass_o[i]), 8'(mpass[i]));
            if (mact[i] && mk[i] <= l && mk[i] % DA[i] == 0)
                f_in[i] = fval(fn_sel, NA[i], ev);
            else
                f_in[i] = 1'($urandom);
        end
    endtask

    task automatic drain();
        start = 1'b0;
        repeat (100) tick();
    endtask

    task automatic set_exp_truth();
        for (int i = 0; i < NI; i++) exp_drv[i] = truth(fn_sel, NA[i]);
    endtask

    task automatic run_all(input int maxc);
        bit all;
        for (int i = 0; i < NI; i++) dat[i] = -1;
        start = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            tick();
            start = 1'b0;
            if (c < 128) vseq[c] = 8'(vec_o[0]);
            all = 1;
            for (int i = 0; i < NI; i++) begin
                if (done_o[i] && dat[i] < 0) dat[i] = c;
                if (dat[i] < 0) all = 0;
            end
            if (all) break;
        end
    endtask

    initial begin
        int  nd;
        bit  found;
        bit  hold;
        for (int i = 0; i < NI; i++) begin
            exp_drv[i] = '0; f_in[i] = 1'b0;
        end

        // Reset held for 3 cycles, then 50 idle cycles.
        repeat (3) tick();
        rst = 1'b0;
        repeat (50) tick();
        chk("lit_idle_tt", 0, tt_o[0], 8'h00);
        chk("lit_idle_vec", 0, 8'(vec_o[0]), 8'h00);

        // AND unit; instance 1 gets a deliberately wrong expectation.
        fn_sel = 0;
        set_exp_truth();
        exp_drv[0] = 8'h08;
        exp_drv[1] = 8'h09;
        run_all(150);
        chk("lit_done_d2",  0, 8'(dat[0]), 8'd10);
        chk("lit_done_d20", 1, 8'(dat[1]), 8'd82);
        chk("lit_done_d4",  2, 8'(dat[2]), 8'd18);
        chk("lit_done_d1",  3, 8'(dat[3]), 8'd6);
        chk("lit_done_n3",  4, 8'(dat[4]), 8'd26);
        for (int c = 1; c <= 9; c++) chk("lit_vseq", c, vseq[c], seq_ref[c-1]);
        chk("lit_tt_d2",   0, tt_o[0],  8'h08);
        chk("lit_pass_d2", 0, 8'(pass_o[0]), 8'd1);
        chk("lit_mis_d2",  0, mis_o[0], 8'h00);
        chk("lit_tt_d20",  1, tt_o[1],  8'h08);
        chk("lit_pass_d20", 1, 8'(pass_o[1]), 8'd0);
        chk("lit_mis_d20", 1, mis_o[1], 8'h01);
        chk("lit_pass_glitch", 2, 8'(pass_o[2]), 8'd1);
        chk("lit_pass_d1", 3, 8'(pass_o[3]), 8'd1);
        chk("lit_tt_n3",   4, tt_o[4],  8'h80);

        // Start re-pulsed and expectation changed mid-sweep.
        drain();
        fn_sel = 1;
        set_exp_truth();
        exp_drv[0] = 8'h06;
        start = 1'b1;
        tick();
        start = 1'b0;
        nd = done_o[0] ? 1 : 0;
        repeat (3) tick();
        start = 1'b1;
        exp_drv[0] = 8'hf9;
        tick();
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done_o[0]) nd++;
        end
        chk("lit_single_sweep", 0, 8'(nd), 8'd1);
        chk("lit_latched_pass", 0, 8'(pass_o[0]), 8'd1);
        chk("lit_latched_tt",   0, tt_o[0], 8'h06);

        // Start held high: back-to-back sweeps with one idle cycle between.
        drain();
        fn_sel = 2;
        set_exp_truth();
        start = 1'b1;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done_o[0]) begin
                found = 1;
                break;
            end
        end
        chk("lit_held_done", 0, 8'(found), 8'd1);
        tick();
        chk("lit_held_gap_busy", 0, 8'(busy_o[0]), 8'd0);
        tick();
        chk("lit_held_rest_busy", 0, 8'(busy_o[0]), 8'd1);
        chk("lit_held_rest_vec",  0, 8'(vec_o[0]), 8'd0);
        start = 1'b0;

        // Asynchronous reset while vector 2 is applied.
        drain();
        fn_sel = 0;
        set_exp_truth();
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 20; c++) begin
            if (vec_o[0] == 3'd2) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("lit_reached_vec2", 0, 8'(found), 8'd1);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) chk("lit_async_busy", i, 8'(busy_o[i]), 8'd0);
        chk("lit_async_vec", 0, 8'(vec_o[0]), 8'd0);
        tick();
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done_o[0]) nd++;
        end
        chk("lit_abort_no_done", 0, 8'(nd), 8'd0);
        chk("lit_abort_tt", 0, tt_o[0], 8'h00);
        fn_sel = 1;
        set_exp_truth();
        exp_drv[0] = 8'h06;
        run_all(150);
        chk("lit_xor_pass", 0, 8'(pass_o[0]), 8'd1);
        chk("lit_xor_tt",   0, tt_o[0], 8'h06);

        // Randomized traffic against the model.
        drain();
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) hold = !hold;
            start = hold || ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 39) == 0) fn_sel = $urandom_range(0, 3);
            if ($urandom_range(0, 59) == 0) rnd_tbl = 8'($urandom);
            for (int i = 0; i < NI; i++)
                if ($urandom_range(0, 9) == 0)
                    exp_drv[i] = ($urandom_range(0, 1) == 1) ? truth(fn_sel, NA[i])
                                                             : 8'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
